piso_tx_ctrl: RTL and testbench

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

---
 rtl/piso_tx_ctrl_pkg.sv | 22 ++
 rtl/piso_tx_ctrl_bit_timer.sv | 30 +++
 rtl/piso_tx_ctrl.sv | 140 ++++++++++++++
 tb/tb_piso_tx_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the PISO transmit controller.
// Optional parity bit is enabled with the PISO_TX_PARITY_EN macro.
package piso_pkg;

  localparam int unsigned STATE_W = 2;

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/piso_tx_ctrl_bit_timer.sv
// Bit-period divider: emits a one-cycle tick on the last clk cycle of each
// DIV-cycle serial bit period; restarted when a new word is accepted.
module bit_timer #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_W'(DIV - 1));
  assign o_tick_c = i_en && w_last;

  // Count cycles within the current bit period
  always_ff @(posedge clk) begin
    if (reset || i_clear || o_tick_c) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmit controller, MSB first, DIV clk per bit.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BIT_W = $clog2(N);

  state_t           r_state;
  logic [N-1:0]     r_shift;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_s_ready;
  logic             r_ser_valid;
  logic             r_frame;
  logic             r_busy;
  logic             r_done;
`ifdef PISO_TX_PARITY_EN
  logic             r_par;
`endif

  logic w_xfer;
  logic w_tick;
  logic w_last_bit;

  assign w_xfer     = s_valid && (r_state == ST_IDLE);
  assign w_last_bit = (r_bit_cnt == BIT_W'(N - 1));

  // The shift register MSB is the line; it is zero whenever no frame is active
  assign ser_out   = r_shift[N-1];
  assign s_ready   = r_s_ready;
  assign ser_valid = r_ser_valid;
  assign frame     = r_frame;
  assign busy      = r_busy;
  assign done      = r_done;

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_xfer),
    .i_en     (r_busy),
    .o_tick_c (w_tick)
  );

  // Frame sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_s_ready   <= 1'b1;
      r_ser_valid <= 1'b0;
      r_frame     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_state     <= ST_SHIFT;
            r_shift     <= s_data;
            r_bit_cnt   <= '0;
            r_s_ready   <= 1'b0;
            r_ser_valid <= 1'b1;
            r_frame     <= 1'b1;
            r_busy      <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            r_par       <= ^s_data;
`endif
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_frame <= 1'b0;
            if (w_last_bit) begin
`ifdef PISO_TX_PARITY_EN
              // Parity rides out through the MSB like a data bit
              r_state <= ST_PAR;
              r_shift <= {r_par, (N - 1)'(0)};
`else
              r_state     <= ST_DONE;
              r_shift     <= '0;
              r_ser_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
`endif
            end else begin
              r_shift   <= {r_shift[N-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        ST_PAR: begin
          if (w_tick) begin
            r_state     <= ST_DONE;
            r_shift     <= '0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b0;
          r_s_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_shift     <= '0;
          r_s_ready   <= 1'b1;
          r_ser_valid <= 1'b0;
          r_frame     <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Self-checking bench for piso_tx_ctrl (N=8, DIV=2 plus a DIV=1 instance).
// Honors PISO_TX_PARITY_EN when the design is built with parity.
module tb_piso_tx_ctrl;

  localparam int unsigned N   = 8;
  localparam int unsigned DIV = 2;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FL = N + PBITS;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] s_data, s_data_b;
  logic         s_valid, s_valid_b;
  logic         s_ready, ser_out, ser_valid, frame, busy, done;
  logic         s_ready_b, ser_out_b, ser_valid_b, frame_b, busy_b, done_b;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.N(N), .DIV(DIV)) u_dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame(frame), .busy(busy), .done(done)
  );

  piso_tx_ctrl #(.N(N), .DIV(1)) u_dut_div1 (
    .clk(clk), .reset(reset), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .frame(frame_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic v;
    logic f;
  } sbit_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mid;
    logic       par;
  } vec_t;

  sbit_t exp_q[$];
  int    done_q[$];
  sbit_t mon_e;
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: DUT produced an event the model did not expect", name, cyc);
  endtask

  // Expected per-cycle line values and done time for a transfer at edge k
  task automatic push_frame(input logic [7:0] d, input logic par, input int k);
    for (int i = N - 1; i >= 0; i--)
      for (int j = 0; j < int'(DIV); j++)
        exp_q.push_back('{d[i], (i == int'(N) - 1)});
    for (int j = 0; j < int'(PBITS * DIV); j++)
      exp_q.push_back('{par, 1'b0});
    done_q.push_back(k + 1 + int'(FL * DIV));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitor for the DIV=2 instance
  always @(negedge clk) begin
    if (mon_en) begin
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          unexpected("extra_bit");
        end else begin
          mon_e = exp_q.pop_front();
          chk("ser_out", 32'(ser_out), 32'(mon_e.v));
          chk("frame", 32'(frame), 32'(mon_e.f));
          chk("busy_in_frame", 32'({busy, s_ready}), 32'h2);
        end
      end else begin
        chk("idle_outputs", 32'({ser_out, frame, busy}), 32'h0);
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("spurious_done");
        else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   k, k2;
    logic [7:0] w;
    logic [7:0] wb[2];

    vt[0] = '{8'hA5, 8'hA5, 1'b0};
    vt[1] = '{8'h07, 8'h07, 1'b1};
    vt[2] = '{8'h5A, 8'h00, 1'b0};
    vt[3] = '{8'h00, 8'hFF, 1'b0};
    vt[4] = '{8'hFE, 8'h00, 1'b1};
    vt[5] = '{8'h81, 8'h3C, 1'b0};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_valid_b = 1'b0; s_data_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_s_ready", 32'(s_ready), 32'h1);
    chk("reset_outputs", 32'({ser_out, ser_valid, frame, busy, done}), 32'h0);
    chk("reset_b", 32'({s_ready_b, ser_out_b, ser_valid_b, frame_b, busy_b, done_b}), 32'h20);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Table of single frames, each issued in the first IDLE cycle after DONE
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s_ready_idle", 32'(s_ready), 32'h1);
      k = cyc;
      s_data = vt[i].data; s_valid = 1'b1;
      push_frame(vt[i].data, vt[i].par, k);
      @(negedge clk);
      s_valid = 1'b0; s_data = vt[i].mid;
      wait_cyc(k + 3);
      s_valid = 1'b1; s_data = 8'hC3;
      @(negedge clk);
      s_valid = 1'b0; s_data = vt[i].mid;
      wait_cyc(k + 1 + int'(FL * DIV));
      chk("s_ready_in_done", 32'(s_ready), 32'h0);
    end

    // s_valid held high across two frames; data changes mid-frame
    @(negedge clk);
    k  = cyc;
    k2 = k + int'(FL * DIV) + 2;
    s_data = 8'h01; s_valid = 1'b1;
    push_frame(8'h01, 1'b1, k);
    push_frame(8'h80, 1'b1, k2);
    wait_cyc(k + 5);
    s_data = 8'h80;
    wait_cyc(k2 + 1);
    s_valid = 1'b0;
    wait_cyc(k2 + 1 + int'(FL * DIV));
    @(negedge clk);

    // Reset in cycle 7 of a frame aborts it without a done pulse
    k = cyc;
    s_data = 8'hC3; s_valid = 1'b1;
    push_frame(8'hC3, 1'b0, k);
    @(negedge clk);
    s_valid = 1'b0;
    wait_cyc(k + 7);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'({s_ready, ser_valid, busy, done, ser_out}), 32'h10);
    exp_q.delete();
    done_q.delete();
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset wins over a simultaneous transfer request
    reset = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0;
    chk("reset_priority", 32'({s_ready, busy, ser_valid}), 32'h4);
    repeat (FL * DIV + 4) @(negedge clk);

    // DIV=1 instance: every cycle is a bit period
    wb[0] = 8'hFF;
    wb[1] = 8'h69;
    for (int m = 0; m < 2; m++) begin
      w = wb[m];
      k = cyc;
      s_data_b = w; s_valid_b = 1'b1;
      @(negedge clk);
      s_valid_b = 1'b0; s_data_b = 8'h00;
      for (int i = 1; i <= int'(FL); i++) begin
        chk("div1_bit", 32'({ser_valid_b, busy_b, ser_out_b}),
            32'({2'b11, (i <= int'(N)) ? w[int'(N) - i] : ^w}));
        chk("div1_frame", 32'(frame_b), 32'(i == 1));
        @(negedge clk);
      end
      chk("div1_done", 32'({done_b, busy_b, ser_valid_b, s_ready_b}), 32'h8);
      chk("div1_done_cycle", 32'(cyc), 32'(k + 1 + int'(FL)));
      @(negedge clk);
      chk("div1_idle", 32'({done_b, s_ready_b}), 32'h1);
    end

    chk("bits_outstanding", 32'(exp_q.size()), 32'h0);
    chk("done_outstanding", 32'(done_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
